// File: rtl/led_matrix_sense.sv
// led_matrix_sense: reads light level through the 4x4 LED matrix pins.
// Each LED row is reverse-biased for CHARGE_CYCLES, the cathodes are released,
// and the time for each cathode to fall to 0 is reported as one count per LED.
// Optional build macro LED_SENSE_CONT_EN: when defined, frames repeat back to
// back until reset instead of returning to IDLE after each frame.
module led_matrix_sense #(
  parameter int unsigned      CHARGE_CYCLES = 48,
  parameter int unsigned      CNT_W         = 16,
  parameter logic [CNT_W-1:0] MAX_COUNT     = 16'hFFFF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             busy,
  output logic [3:0]       aled_out,
  output logic [3:0]       kled_oe,
  output logic [3:0]       kled_out,
  input  logic [3:0]       kled_in,
  output logic             result_valid,
  output logic [3:0]       result_idx,
  output logic [CNT_W-1:0] result_val,
  output logic             frame_done
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CHARGE    = 2'd1,
    DISCHARGE = 2'd2,
    REPORT    = 2'd3
  } state_t;

  localparam logic [15:0] CHARGE_LAST = 16'(CHARGE_CYCLES - 1);

  state_t           state;
  logic [1:0]       row;
  logic [1:0]       col;
  logic [15:0]      charge_cnt;
  logic [CNT_W-1:0] dis_cnt;
  logic [3:0]       done_mask;
  logic [CNT_W-1:0] cnt [4];
  logic [3:0]       sync1;
  logic [3:0]       ks;

  logic [3:0]       hit;
  logic             all_latched;
  logic [CNT_W-1:0] final_cnt [4];

  // Two-flop synchroniser; preloaded to "charged" whenever the cathodes are not
  // being sensed, so every row starts from a clean high reading and a pin that is
  // stuck low reports the synchroniser latency rather than stale data.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= 4'b1111;
      ks    <= 4'b1111;
    end else if (state != DISCHARGE) begin
      sync1 <= 4'b1111;
      ks    <= 4'b1111;
    end else begin
      sync1 <= kled_in;
      ks    <= sync1;
    end
  end

  // Columns discharging this cycle and the count each column ends the row with.
  always_comb begin
    hit         = ~done_mask & ~ks;
    all_latched = &(done_mask | hit);
    for (int c = 0; c < 4; c++) begin
      if (done_mask[c]) begin
        final_cnt[c] = cnt[c];
      end else if (hit[c]) begin
        final_cnt[c] = dis_cnt;
      end else begin
        final_cnt[c] = MAX_COUNT;
      end
    end
  end

  // Main sequencer: charge, time the discharge, stream four results per row.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      aled_out     <= 4'b0000;
      kled_oe      <= 4'b0000;
      kled_out     <= 4'b0000;
      result_valid <= 1'b0;
      result_idx   <= 4'd0;
      result_val   <= '0;
      frame_done   <= 1'b0;
      row          <= 2'd0;
      col          <= 2'd0;
      charge_cnt   <= 16'd0;
      dis_cnt      <= '0;
      done_mask    <= 4'b0000;
      for (int c = 0; c < 4; c++) cnt[c] <= '0;
    end else begin
      aled_out     <= 4'b0000;
      result_valid <= 1'b0;
      frame_done   <= 1'b0;
      case (state)
        IDLE: begin
          // A start coinciding with the previous frame_done is dropped.
          if (start && !frame_done) begin
            state      <= CHARGE;
            busy       <= 1'b1;
            row        <= 2'd0;
            charge_cnt <= 16'd0;
            kled_oe    <= 4'b1111;
            kled_out   <= 4'b1111;
          end
        end
        CHARGE: begin
          if (charge_cnt == CHARGE_LAST) begin
            state     <= DISCHARGE;
            kled_oe   <= 4'b0000;
            kled_out  <= 4'b0000;
            dis_cnt   <= CNT_W'(1);
            done_mask <= 4'b0000;
          end else begin
            charge_cnt <= charge_cnt + 16'd1;
          end
        end
        DISCHARGE: begin
          done_mask <= done_mask | hit;
          if (all_latched || (dis_cnt == MAX_COUNT)) begin
            for (int c = 0; c < 4; c++) cnt[c] <= final_cnt[c];
            state        <= REPORT;
            col          <= 2'd0;
            result_valid <= 1'b1;
            result_idx   <= {row, 2'd0};
            result_val   <= final_cnt[0];
          end else begin
            for (int c = 0; c < 4; c++) begin
              if (hit[c]) cnt[c] <= dis_cnt;
            end
            dis_cnt <= dis_cnt + 1'b1;
          end
        end
        REPORT: begin
          if (col != 2'd3) begin
            col          <= col + 2'd1;
            result_valid <= 1'b1;
            result_idx   <= {row, col + 2'd1};
            result_val   <= cnt[col + 2'd1];
          end else if (row != 2'd3) begin
            row        <= row + 2'd1;
            state      <= CHARGE;
            charge_cnt <= 16'd0;
            kled_oe    <= 4'b1111;
            kled_out   <= 4'b1111;
          end else begin
            frame_done <= 1'b1;
`ifdef LED_SENSE_CONT_EN
            row        <= 2'd0;
            state      <= CHARGE;
            charge_cnt <= 16'd0;
            kled_oe    <= 4'b1111;
            kled_out   <= 4'b1111;
`else
            busy       <= 1'b0;
            state      <= IDLE;
`endif
          end
        end
        default: begin
          state   <= IDLE;
          busy    <= 1'b0;
          kled_oe <= 4'b0000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_matrix_sense.sv
// Directed bench for led_matrix_sense: table of per-column discharge delays with
// hand-computed counts, plus hand sequences for start handling and mid-frame reset.
`timescale 1ns/1ps
module tb_led_matrix_sense;

  localparam int CH    = 4;
  localparam int MAXC  = 100;
  localparam int NEVER = 100000;
`ifdef LED_SENSE_CONT_EN
  localparam logic BUSY_AT_FD = 1'b1;
`else
  localparam logic BUSY_AT_FD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic [3:0]  aled_out;
  logic [3:0]  kled_oe;
  logic [3:0]  kled_out;
  logic [3:0]  kled_in;
  logic        result_valid;
  logic [3:0]  result_idx;
  logic [15:0] result_val;
  logic        frame_done;

  led_matrix_sense #(
    .CHARGE_CYCLES(CH),
    .CNT_W(16),
    .MAX_COUNT(16'd100)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy),
    .aled_out(aled_out), .kled_oe(kled_oe), .kled_out(kled_out), .kled_in(kled_in),
    .result_valid(result_valid), .result_idx(result_idx), .result_val(result_val),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // ---------------- cathode model: drop bit c drop[c] cycles into DISCHARGE
  int unsigned drop [4];
  int          dis_cyc = 0;
  logic [3:0]  prev_oe = 4'h0;

  initial begin
    kled_in = 4'hF;
    forever begin
      @(posedge clk);
      #1;
      if (kled_oe == 4'hF) dis_cyc = 0;
      else if (prev_oe == 4'hF) dis_cyc = 1;
      else if (dis_cyc > 0) dis_cyc++;
      prev_oe = kled_oe;
      for (int c = 0; c < 4; c++) begin
        if (drop[c] == 0) kled_in[c] = 1'b0;
        else if (dis_cyc > 0 && dis_cyc >= int'(drop[c])) kled_in[c] = 1'b0;
        else kled_in[c] = 1'b1;
      end
    end
  end

  // ---------------- monitor
  typedef struct packed { logic [3:0] idx; logic [15:0] val; } res_t;
  res_t resq[$];
  int   rv_count  = 0;
  int   fd_count  = 0;
  int   chg_cyc   = 0;
  int   busy_drop = 0;
  bit   mon_en    = 1'b0;
  bit   cont_mon  = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      check("aled_out_low", aled_out, 4'h0);
      if (result_valid) begin
        resq.push_back({result_idx, result_val});
        rv_count++;
      end
      if (frame_done) begin
        fd_count++;
        check("busy_at_frame_done", busy, BUSY_AT_FD);
      end
      if (kled_oe == 4'hF) begin
        chg_cyc++;
        check("kled_out_charge", kled_out, 4'hF);
      end
      if (cont_mon && !busy) busy_drop++;
    end
  end

  // ---------------- vector table
  typedef struct {
    string       name;
    int unsigned drop [4];
    int unsigned expv [4];
  } vec_t;
  vec_t vecs [4];

  // Expected frame length from accept edge to frame_done cycle.
  function automatic int frame_len(input int v);
    int m = 0;
    for (int c = 0; c < 4; c++) if (int'(vecs[v].expv[c]) > m) m = int'(vecs[v].expv[c]);
    return 4 * (CH + m + 4) + 1;
  endfunction

  // Called #1 after an edge; start goes high for exactly one cycle from now.
  task automatic run_frame(input int v);
    int cyc;
    int fd0;
    int chg0;
    drop = vecs[v].drop;
    resq.delete();
    fd0  = fd_count;
    chg0 = chg_cyc;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({vecs[v].name, "_busy_rise"}, busy, 1'b1);
    cyc = 1;
    while (!frame_done && cyc < 2000) begin
      start = (cyc == 30);      // start while busy must be dropped
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    check({vecs[v].name, "_latency"}, cyc, frame_len(v));
    // start coincident with frame_done must be dropped
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({vecs[v].name, "_coincident_start_dropped"}, busy, 1'b0);
    check({vecs[v].name, "_frame_done_once"}, fd_count - fd0, 1);
    check({vecs[v].name, "_charge_cycles"}, chg_cyc - chg0, 4 * CH);
    check({vecs[v].name, "_result_count"}, resq.size(), 16);
    for (int i = 0; i < resq.size() && i < 16; i++) begin
      check({vecs[v].name, "_idx"}, resq[i].idx, i);
      check({vecs[v].name, "_val"}, resq[i].val, vecs[v].expv[i % 4]);
    end
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    drop = '{NEVER, NEVER, NEVER, NEVER};

    vecs[0].name = "dark";
    vecs[0].drop = '{NEVER, NEVER, NEVER, NEVER};
    vecs[0].expv = '{MAXC, MAXC, MAXC, MAXC};
    vecs[1].name = "staggered";
    vecs[1].drop = '{10, 20, 30, 40};
    vecs[1].expv = '{12, 22, 32, 42};
    vecs[2].name = "instant";
    vecs[2].drop = '{0, 0, 0, 0};
    vecs[2].expv = '{3, 3, 3, 3};
    vecs[3].name = "mixed";
    vecs[3].drop = '{3, 0, 50, 20};
    vecs[3].expv = '{5, 3, 52, 22};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1'b0);
    check("rst_aled_out", aled_out, 4'h0);
    check("rst_kled_oe", kled_oe, 4'h0);
    check("rst_kled_out", kled_out, 4'h0);
    check("rst_result_valid", result_valid, 1'b0);
    check("rst_result_idx", result_idx, 4'h0);
    check("rst_result_val", result_val, 16'h0);
    check("rst_frame_done", frame_done, 1'b0);
    rst = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;
    check("idle_no_start_busy", busy, 1'b0);

`ifdef LED_SENSE_CONT_EN
    begin
      int cyc;
      drop = vecs[1].drop;
      resq.delete();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("cont_busy_rise", busy, 1'b1);
      cont_mon = 1'b1;
      cyc = 0;
      while (fd_count < 3 && cyc < 3000) begin
        start = (cyc == 100);   // ignored in continuous mode
        @(posedge clk); #1;
        cyc++;
      end
      start = 1'b0;
      @(negedge clk);
      cont_mon = 1'b0;
      check("cont_frame_done_count", fd_count, 3);
      check("cont_busy_never_low", busy_drop, 0);
      check("cont_result_count_min", resq.size() >= 48, 1'b1);
      for (int i = 0; i < resq.size() && i < 48; i++) begin
        check("cont_idx_wrap", resq[i].idx, i % 16);
        check("cont_val", resq[i].val, vecs[1].expv[i % 4]);
      end
      @(posedge clk); #1;
    end
`else
    for (int v = 0; v < 4; v++) run_frame(v);
`endif

    // reset asserted mid-DISCHARGE aborts the frame
    begin
      int rv0;
      int fd0;
      drop = '{NEVER, NEVER, NEVER, NEVER};
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (25) @(posedge clk);
      #1;
      check("pre_rst_in_discharge", {busy, kled_oe}, {1'b1, 4'h0});
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("midrst_busy", busy, 1'b0);
      check("midrst_kled_oe", kled_oe, 4'h0);
      check("midrst_aled_out", aled_out, 4'h0);
      check("midrst_result_valid", result_valid, 1'b0);
      rv0 = rv_count;
      fd0 = fd_count;
      repeat (500) @(posedge clk);
      #1;
      check("midrst_no_results", rv_count - rv0, 0);
      check("midrst_no_frame_done", fd_count - fd0, 0);
      check("midrst_stays_idle", busy, 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
